tm_sos_state_bank: RTL and testbench
====================================

// Module: tm_sos_state_bank
// PURPOSE
//  Parametrised state memory and slot sequencer for the time-multiplexed cascaded-SOS IIR datapath.
//  Holds both direct-form-II delay states (w[n-1], w[n-2]) for every section of every channel.
//  One in_valid strobe starts a run of NO_CH*NO_SOS slots, one slot per CLK.
//  Each slot presents the current section's states and writes back the newly computed w[n].
//  Sits between the shared MAC datapath and the coefficient ROM, which is addressed by sec_idx.
// PARAMETERS
//  BW      9   state word width, signed two's complement
//  NO_SOS  4   biquad sections per channel (>=1)
//  NO_CH   2   independent channels sharing the datapath (>=1)
//  localparam SEC_W = max(1,$clog2(NO_SOS)), CH_W = max(1,$clog2(NO_CH)), DEPTH = NO_CH*NO_SOS
// PORTS
//  CLK        in   1      clock, all state on rising edge
//  RESET      in   1      synchronous, active-low reset
//  in_valid   in   1      start-of-sample strobe; starts a run
//  clear      in   1      synchronous flush of all stored states (filter restart)
//  w_in       in   BW     new w[n] for the current slot from the datapath (signed)
//  w1_out     out  BW     w[n-1] of current slot (signed)
//  w2_out     out  BW     w[n-2] of current slot (signed)
//  sec_idx    out  SEC_W  current section index
//  ch_idx     out  CH_W   current channel index
//  busy       out  1      high during every slot of a run
//  first_sec  out  1      busy && sec_idx==0 (datapath selects external x as section input)
//  last_sec   out  1      busy && sec_idx==NO_SOS-1 (datapath latches channel output)
//  done       out  1      one-cycle pulse, the cycle after the final slot of a run
//  overrun    out  1      sticky: in_valid arrived while busy and was not accepted
// BEHAVIOUR
//  Reset (RESET==0 at the edge):
//   - all w1/w2 entries 0; FSM IDLE; sec_idx=0, ch_idx=0.
//   - busy=0, done=0, overrun=0; w1_out=w2_out=0.
//   - Reset overrides every other input, including mid-run: the run is abandoned, no writes land.
//  FSM IDLE / RUN:
//   - IDLE: in_valid=1 -> RUN next cycle, starting at slot (ch 0, sec 0).
//   - RUN: exactly one slot per cycle. Order is channel-major: ch0 sec0..NO_SOS-1, then ch1, ...
//   - A run always lasts DEPTH cycles.
//  Read path:
//   - w1_out/w2_out are combinational reads of the entry at {ch_idx,sec_idx}.
//   - Zero-cycle latency, so the datapath computes w_in within the same cycle.
//   - Outside RUN, both outputs read 0.
//  Write path:
//   - Every RUN cycle, at the closing edge: w2[slot] <= w1[slot] and w1[slot] <= w_in.
//   - No writes in IDLE.
//  Last slot (ch NO_CH-1, sec NO_SOS-1):
//   - Next cycle: done=1, indices wrap to 0.
//   - If in_valid=1 on the last-slot cycle, it is accepted: back-to-back run, no idle gap, busy stays 1.
//   - Otherwise the FSM returns to IDLE.
//  in_valid while busy and not on the last slot:
//   - Ignored; overrun set to 1 and held until RESET or clear.
//  clear=1:
//   - Next edge: all entries 0, FSM IDLE, indices 0, overrun 0, done 0.
//   - Any in-flight run is aborted without writeback.
//   - clear has priority over in_valid in the same cycle.
//  Arithmetic: storage only, no arithmetic on samples; widths preserved exactly (BW in, BW out).
//  Degenerate cases:
//   - NO_SOS=1: first_sec and last_sec are both high every slot.
//   - NO_CH=1: ch_idx is constant 0.
// STRUCTURE
//  Shared package tm_iir_pkg: default BW/NO_SOS/NO_CH and FSM state encodings (IDLE=0, RUN=1).
//   - Shared with the coefficient ROM and the MAC datapath.
//  Sub-module tm_slot_sequencer: FSM, nested sec/ch counters with wrap, busy/first/last/done/overrun.
//  Top level: sequencer plus two DEPTH x BW register arrays and the read mux.
// TESTING
//  1 Reset: RESET=0 for 2 cycles, then 1 -> all outputs 0, busy=0; a first run reads w1=w2=0 in every slot.
//  2 Run order: NO_SOS=4, NO_CH=2, one in_valid pulse ->
//     - busy high for 8 cycles; (ch,sec) = (0,0)..(0,3),(1,0)..(1,3).
//     - first_sec in cycles 1 and 5; last_sec in cycles 4 and 8; done in cycle 9.
//  3 Delay line: drive w_in = 10*ch + sec + 100*run over runs 1..3 ->
//     - in run 3, slot (1,2) reads w1=212, w2=112.
//  4 Back-to-back: in_valid asserted on the last-slot cycle ->
//     - new run starts at (0,0) the next cycle, done and busy both 1 that cycle, overrun stays 0.
//  5 Overrun: in_valid at slot (0,2) -> ignored, run finishes normally, overrun=1 until clear.
//  6 Mid-run abort: clear at slot (1,1) with w_in=55 ->
//     - no write lands; next cycle IDLE; a following run reads all states 0.
//     - Repeat with RESET=0 instead of clear: same result.

Source files
------------

// File: rtl/tm_iir_pkg.sv
// Shared definitions for the time-multiplexed cascaded-SOS IIR: default sizes,
// sequencer state encoding and the index-width helper.
package tm_iir_pkg;

    localparam int BW_DEF     = 9;
    localparam int NO_SOS_DEF = 4;
    localparam int NO_CH_DEF  = 2;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } seq_state_t;

    // Index width for a counter over n items, never narrower than one bit.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/tm_sos_state_bank_if.sv
// Slot bus between the shared MAC datapath (master) and the SOS state bank (slave).
interface tm_sos_state_bank_if import tm_iir_pkg::*; #(
    parameter int BW     = BW_DEF,
    parameter int NO_SOS = NO_SOS_DEF,
    parameter int NO_CH  = NO_CH_DEF
) ();

    localparam int SEC_W = idx_w(NO_SOS);
    localparam int CH_W  = idx_w(NO_CH);

    logic                    in_valid;
    logic                    clear;
    logic signed [BW-1:0]    w_in;
    logic signed [BW-1:0]    w1_out;
    logic signed [BW-1:0]    w2_out;
    logic        [SEC_W-1:0] sec_idx;
    logic        [CH_W-1:0]  ch_idx;
    logic                    busy;
    logic                    first_sec;
    logic                    last_sec;
    logic                    done;
    logic                    overrun;

    modport master (
        output in_valid, clear, w_in,
        input  w1_out, w2_out, sec_idx, ch_idx, busy, first_sec, last_sec, done, overrun
    );

    modport slave (
        input  in_valid, clear, w_in,
        output w1_out, w2_out, sec_idx, ch_idx, busy, first_sec, last_sec, done, overrun
    );

endinterface

// File: rtl/tm_slot_sequencer.sv
// Walks the (channel, section) slots of one run, channel-major, one slot per clock,
// and flags run boundaries and dropped start strobes.
module tm_slot_sequencer import tm_iir_pkg::*; #(
    parameter int NO_SOS = NO_SOS_DEF,
    parameter int NO_CH  = NO_CH_DEF,
    parameter int SEC_W  = idx_w(NO_SOS),
    parameter int CH_W   = idx_w(NO_CH)
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             in_valid,
    input  logic             clear,
    output logic [SEC_W-1:0] sec_idx,
    output logic [CH_W-1:0]  ch_idx,
    output logic             busy,
    output logic             first_sec,
    output logic             last_sec,
    output logic             done,
    output logic             overrun
);

    seq_state_t       state, state_nx;
    logic [SEC_W-1:0] sec_nx;
    logic [CH_W-1:0]  ch_nx;
    logic             sec_end;
    logic             last_slot;

    assign busy      = (state == RUN);
    assign sec_end   = (sec_idx == SEC_W'(NO_SOS - 1));
    assign first_sec = busy && (sec_idx == '0);
    assign last_sec  = busy && sec_end;
    assign last_slot = last_sec && (ch_idx == CH_W'(NO_CH - 1));

    always_ff @(posedge CLK) begin
        if (!RESET || clear) begin
            state   <= IDLE;
            sec_idx <= '0;
            ch_idx  <= '0;
            done    <= 1'b0;
            overrun <= 1'b0;
        end else begin
            state   <= state_nx;
            sec_idx <= sec_nx;
            ch_idx  <= ch_nx;
            done    <= last_slot;
            if (busy && in_valid && !last_slot) begin
                overrun <= 1'b1;
            end
        end
    end

    always_comb begin
        state_nx = state;
        sec_nx   = sec_idx;
        ch_nx    = ch_idx;
        case (state)
            IDLE: begin
                if (in_valid) begin
                    state_nx = RUN;
                end
            end
            RUN: begin
                if (sec_end) begin
                    sec_nx = '0;
                    if (last_slot) begin
                        ch_nx    = '0;
                        // A strobe on the final slot chains straight into the next run.
                        state_nx = in_valid ? RUN : IDLE;
                    end else begin
                        ch_nx = ch_idx + 1'b1;
                    end
                end else begin
                    sec_nx = sec_idx + 1'b1;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

endmodule

// File: rtl/tm_sos_state_bank.sv
// Direct-form-II delay-state memory for every section of every channel, read
// combinationally for the current slot and shifted by one sample at the slot's closing edge.
module tm_sos_state_bank import tm_iir_pkg::*; #(
    parameter int BW     = BW_DEF,
    parameter int NO_SOS = NO_SOS_DEF,
    parameter int NO_CH  = NO_CH_DEF
) (
    input logic                CLK,
    input logic                RESET,
    tm_sos_state_bank_if.slave bus
);

    localparam int SEC_W = idx_w(NO_SOS);
    localparam int CH_W  = idx_w(NO_CH);
    localparam int DEPTH = NO_CH * NO_SOS;
    localparam int AW    = idx_w(DEPTH);

    logic signed [BW-1:0] w1_mem [DEPTH];
    logic signed [BW-1:0] w2_mem [DEPTH];
    logic        [AW-1:0] slot;

    tm_slot_sequencer #(
        .NO_SOS (NO_SOS),
        .NO_CH  (NO_CH),
        .SEC_W  (SEC_W),
        .CH_W   (CH_W)
    ) u_seq (
        .CLK       (CLK),
        .RESET     (RESET),
        .in_valid  (bus.in_valid),
        .clear     (bus.clear),
        .sec_idx   (bus.sec_idx),
        .ch_idx    (bus.ch_idx),
        .busy      (bus.busy),
        .first_sec (bus.first_sec),
        .last_sec  (bus.last_sec),
        .done      (bus.done),
        .overrun   (bus.overrun)
    );

    // Linear slot address so NO_SOS need not be a power of two.
    assign slot = AW'(int'(bus.ch_idx) * NO_SOS + int'(bus.sec_idx));

    assign bus.w1_out = bus.busy ? w1_mem[slot] : '0;
    assign bus.w2_out = bus.busy ? w2_mem[slot] : '0;

    always_ff @(posedge CLK) begin
        if (!RESET || bus.clear) begin
            for (int i = 0; i < DEPTH; i++) begin
                w1_mem[i] <= '0;
                w2_mem[i] <= '0;
            end
        end else if (bus.busy) begin
            w2_mem[slot] <= w1_mem[slot];
            w1_mem[slot] <= bus.w_in;
        end
    end

endmodule

// File: tb/tb_tm_sos_state_bank.sv
// Self-checking bench for tm_sos_state_bank (BW=9, NO_SOS=4, NO_CH=2) using a
// per-cycle reference model feeding a scoreboard queue, plus scenario checks.
module tb_tm_sos_state_bank;
    import tm_iir_pkg::*;

    localparam int BW     = 9;
    localparam int NO_SOS = 4;
    localparam int NO_CH  = 2;
    localparam int DEPTH  = NO_CH * NO_SOS;

    typedef struct packed {
        logic                 busy;
        logic                 first;
        logic                 last;
        logic                 done;
        logic                 ovr;
        logic [1:0]           sec;
        logic                 ch;
        logic signed [BW-1:0] w1;
        logic signed [BW-1:0] w2;
    } vec_t;

    logic CLK   = 1'b0;
    logic RESET = 1'b0;
    always #5 CLK = ~CLK;

    tm_sos_state_bank_if #(.BW(BW), .NO_SOS(NO_SOS), .NO_CH(NO_CH)) bus ();

    tm_sos_state_bank #(.BW(BW), .NO_SOS(NO_SOS), .NO_CH(NO_CH)) dut (
        .CLK   (CLK),
        .RESET (RESET),
        .bus   (bus)
    );

    int   vectors     = 0;
    int   miscompares = 0;
    vec_t sb[$];

    logic                 m_busy = 1'b0;
    logic                 m_done = 1'b0;
    logic                 m_ovr  = 1'b0;
    logic [2:0]           m_slot = 3'd0;
    logic signed [BW-1:0] mw1 [DEPTH];
    logic signed [BW-1:0] mw2 [DEPTH];

    // One clock: drive inputs after the edge, predict, compare mid-cycle, advance the model.
    task automatic cycle(input logic r, input logic v, input logic c, input logic signed [BW-1:0] w);
        vec_t e;
        vec_t o;
        @(posedge CLK);
        #1;
        RESET        = r;
        bus.in_valid = v;
        bus.clear    = c;
        bus.w_in     = w;
        e.busy  = m_busy;
        e.sec   = m_slot[1:0];
        e.ch    = m_slot[2];
        e.first = m_busy && (m_slot[1:0] == 2'd0);
        e.last  = m_busy && (m_slot[1:0] == 2'd3);
        e.done  = m_done;
        e.ovr   = m_ovr;
        e.w1    = m_busy ? mw1[m_slot] : '0;
        e.w2    = m_busy ? mw2[m_slot] : '0;
        sb.push_back(e);
        #3;
        o = {bus.busy, bus.first_sec, bus.last_sec, bus.done, bus.overrun,
             bus.sec_idx, bus.ch_idx, bus.w1_out, bus.w2_out};
        e = sb.pop_front();
        vectors++;
        if (o !== e) begin
            miscompares++;
            $display("FAIL scoreboard t=%0t got busy=%b first=%b last=%b done=%b ovr=%b sec=%0d ch=%0d w1=%0d w2=%0d, expected busy=%b first=%b last=%b done=%b ovr=%b sec=%0d ch=%0d w1=%0d w2=%0d",
                     $time, o.busy, o.first, o.last, o.done, o.ovr, o.sec, o.ch, o.w1, o.w2,
                     e.busy, e.first, e.last, e.done, e.ovr, e.sec, e.ch, e.w1, e.w2);
        end
        if (!r || c) begin
            for (int i = 0; i < DEPTH; i++) begin
                mw1[i] = '0;
                mw2[i] = '0;
            end
            m_busy = 1'b0;
            m_slot = 3'd0;
            m_done = 1'b0;
            m_ovr  = 1'b0;
        end else begin
            m_done = 1'b0;
            if (m_busy) begin
                mw2[m_slot] = mw1[m_slot];
                mw1[m_slot] = w;
                if (m_slot == 3'd7) begin
                    m_done = 1'b1;
                    m_slot = 3'd0;
                    m_busy = v;
                end else begin
                    m_slot = m_slot + 3'd1;
                    if (v) m_ovr = 1'b1;
                end
            end else if (v) begin
                m_busy = 1'b1;
            end
        end
    endtask

    task automatic test_reset();
        for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 1'b0, '0);
        vectors++;
        if ({bus.busy, bus.done, bus.overrun, bus.sec_idx, bus.ch_idx, bus.w1_out, bus.w2_out} !== 23'd0) begin
            miscompares++;
            $display("FAIL reset_outputs got busy=%b done=%b ovr=%b sec=%0d ch=%0d w1=%0d w2=%0d, expected all 0",
                     bus.busy, bus.done, bus.overrun, bus.sec_idx, bus.ch_idx, bus.w1_out, bus.w2_out);
        end
    endtask

    // Run 1 of the delay-line pattern; also checks slot order and flag timing.
    task automatic test_run_order();
        cycle(1'b1, 1'b1, 1'b0, '0);
        for (int k = 1; k <= 8; k++) begin
            int s;
            int ch;
            int sec;
            s   = k - 1;
            ch  = s / NO_SOS;
            sec = s % NO_SOS;
            cycle(1'b1, 1'b0, 1'b0, 9'(10 * ch + sec + 100));
            vectors++;
            if ({bus.busy, bus.ch_idx, bus.sec_idx, bus.first_sec, bus.last_sec, bus.w1_out, bus.w2_out}
                !== {1'b1, 1'(ch), 2'(sec), (k == 1 || k == 5), (k == 4 || k == 8), 9'sd0, 9'sd0}) begin
                miscompares++;
                $display("FAIL run_order cycle %0d got busy=%b ch=%0d sec=%0d first=%b last=%b w1=%0d w2=%0d, expected busy=1 ch=%0d sec=%0d first=%b last=%b w1=0 w2=0",
                         k, bus.busy, bus.ch_idx, bus.sec_idx, bus.first_sec, bus.last_sec, bus.w1_out, bus.w2_out,
                         ch, sec, (k == 1 || k == 5), (k == 4 || k == 8));
            end
        end
        cycle(1'b1, 1'b0, 1'b0, '0);
        vectors++;
        if ({bus.done, bus.busy} !== 2'b10) begin
            miscompares++;
            $display("FAIL run_done got done=%b busy=%b, expected done=1 busy=0", bus.done, bus.busy);
        end
    endtask

    task automatic test_delay_line();
        for (int run = 2; run <= 3; run++) begin
            cycle(1'b1, 1'b1, 1'b0, '0);
            for (int s = 0; s < DEPTH; s++) begin
                cycle(1'b1, 1'b0, 1'b0, 9'(10 * (s / NO_SOS) + (s % NO_SOS) + 100 * run));
                if (run == 3 && s == 6) begin
                    vectors++;
                    if ({bus.w1_out, bus.w2_out} !== {9'sd212, 9'sd112}) begin
                        miscompares++;
                        $display("FAIL delay_line slot(1,2) got w1=%0d w2=%0d, expected w1=212 w2=112",
                                 bus.w1_out, bus.w2_out);
                    end
                end
            end
            cycle(1'b1, 1'b0, 1'b0, '0);
        end
    endtask

    task automatic test_back_to_back();
        cycle(1'b1, 1'b1, 1'b0, '0);
        for (int s = 0; s < DEPTH - 1; s++) cycle(1'b1, 1'b0, 1'b0, 9'(s + 40));
        cycle(1'b1, 1'b1, 1'b0, 9'sd47);
        cycle(1'b1, 1'b0, 1'b0, 9'sd60);
        vectors++;
        if ({bus.busy, bus.done, bus.overrun, bus.ch_idx, bus.sec_idx} !== 6'b110_000) begin
            miscompares++;
            $display("FAIL back_to_back got busy=%b done=%b ovr=%b ch=%0d sec=%0d, expected busy=1 done=1 ovr=0 ch=0 sec=0",
                     bus.busy, bus.done, bus.overrun, bus.ch_idx, bus.sec_idx);
        end
        for (int s = 1; s < DEPTH; s++) cycle(1'b1, 1'b0, 1'b0, 9'(s + 60));
        cycle(1'b1, 1'b0, 1'b0, '0);
    endtask

    task automatic test_overrun();
        cycle(1'b1, 1'b1, 1'b0, '0);
        for (int s = 0; s < DEPTH; s++) begin
            cycle(1'b1, (s == 2), 1'b0, 9'(-s));
            if (s == 3) begin
                vectors++;
                if ({bus.overrun, bus.busy, bus.sec_idx} !== 4'b1111) begin
                    miscompares++;
                    $display("FAIL overrun_set got ovr=%b busy=%b sec=%0d, expected ovr=1 busy=1 sec=3",
                             bus.overrun, bus.busy, bus.sec_idx);
                end
            end
        end
        cycle(1'b1, 1'b0, 1'b0, '0);
        cycle(1'b1, 1'b0, 1'b0, '0);
        vectors++;
        if ({bus.overrun, bus.busy} !== 2'b10) begin
            miscompares++;
            $display("FAIL overrun_sticky got ovr=%b busy=%b, expected ovr=1 busy=0", bus.overrun, bus.busy);
        end
        cycle(1'b1, 1'b0, 1'b1, '0);
        cycle(1'b1, 1'b0, 1'b0, '0);
        vectors++;
        if (bus.overrun !== 1'b0) begin
            miscompares++;
            $display("FAIL overrun_clear got ovr=%b, expected 0", bus.overrun);
        end
    endtask

    // Abort at slot (1,1); use_reset selects RESET instead of clear.
    task automatic test_abort(input logic use_reset);
        cycle(1'b1, 1'b1, 1'b0, '0);
        for (int s = 0; s < 5; s++) cycle(1'b1, 1'b0, 1'b0, 9'(s + 1));
        if (use_reset) cycle(1'b0, 1'b0, 1'b0, 9'sd55);
        else           cycle(1'b1, 1'b0, 1'b1, 9'sd55);
        cycle(1'b1, 1'b0, 1'b0, '0);
        vectors++;
        if ({bus.busy, bus.done, bus.ch_idx, bus.sec_idx} !== 5'd0) begin
            miscompares++;
            $display("FAIL abort_idle reset=%b got busy=%b done=%b ch=%0d sec=%0d, expected all 0",
                     use_reset, bus.busy, bus.done, bus.ch_idx, bus.sec_idx);
        end
        cycle(1'b1, 1'b1, 1'b0, '0);
        for (int s = 0; s < DEPTH; s++) begin
            cycle(1'b1, 1'b0, 1'b0, 9'(s + 30));
            vectors++;
            if ({bus.w1_out, bus.w2_out} !== 18'd0) begin
                miscompares++;
                $display("FAIL abort_states reset=%b slot %0d got w1=%0d w2=%0d, expected 0 0",
                         use_reset, s, bus.w1_out, bus.w2_out);
            end
        end
        cycle(1'b1, 1'b0, 1'b0, '0);
    endtask

    task automatic test_clear_priority();
        cycle(1'b1, 1'b1, 1'b1, '0);
        cycle(1'b1, 1'b0, 1'b0, '0);
        vectors++;
        if (bus.busy !== 1'b0) begin
            miscompares++;
            $display("FAIL clear_priority got busy=%b, expected 0", bus.busy);
        end
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) begin
            mw1[i] = '0;
            mw2[i] = '0;
        end
        bus.in_valid = 1'b0;
        bus.clear    = 1'b0;
        bus.w_in     = '0;
        RESET        = 1'b0;
        repeat (2) @(posedge CLK);
        test_reset();
        test_run_order();
        test_delay_line();
        test_back_to_back();
        test_overrun();
        test_abort(1'b0);
        test_abort(1'b1);
        test_clear_priority();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
